// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Purpose : Types and constants shared by the UART receiver, transmitter and
//           register file.
// Contents: rx_state_t  - receiver FSM states
//           MIN_BAUDDIV - smallest clocks-per-bit value the UART honours
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int MIN_BAUDDIV = 2;

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Purpose : Two-flop synchronizer for a single asynchronous input bit.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset, loads RST_VAL into both flops
//           d     - asynchronous input
//           q     - synchronized output
// ---------------------------------------------------------------------------
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Purpose : UART receiver, 1 start bit, DW data bits LSB first, 1 stop bit,
//           programmable clocks-per-bit, single-entry data register with
//           overrun and framing error pulses.
// Ports   : clk     - clock
//           rst_n   - asynchronous active-low reset
//           en      - receiver enable (0 forces IDLE)
//           bauddiv - clocks per bit, values below MIN_BAUDDIV act as MIN_BAUDDIV
//           rx      - asynchronous serial input, idle high
//           dread   - one-cycle pulse consuming dout
//           dout    - last received word
//           dvalid  - dout holds unread data
//           ferr    - one-cycle pulse on a framing error
//           oerr    - one-cycle pulse on an overrun
//           busy    - receiver is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DW   = 8,
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [DIVW-1:0] bauddiv,
  input  logic            rx,
  input  logic            dread,
  output logic [DW-1:0]   dout,
  output logic            dvalid,
  output logic            ferr,
  output logic            oerr,
  output logic            busy
);

  localparam int BW = $clog2(DW + 1);

  rx_state_t       state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic            rxs;
  logic            frame_ok;
  logic            frame_bad;
  logic [DIVW-1:0] half_last;
  logic [DIVW-1:0] bit_last;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  // Start bit is checked half a bit in so data/stop samples land mid-bit.
  assign half_last = (div_q >> 1) - DIVW'(1);
  assign bit_last  = div_q - DIVW'(1);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            cnt_d   = '0;
            // Divisor is frozen for the whole frame.
            div_d   = (bauddiv < DIVW'(MIN_BAUDDIV)) ? DIVW'(MIN_BAUDDIV) : bauddiv;
          end
        end
        START: begin
          if (cnt_q == half_last) begin
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d  = DATA;
              cnt_d    = '0;
              bitcnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + DIVW'(1);
          end
        end
        DATA: begin
          if (cnt_q == bit_last) begin
            shreg_d  = {rxs, shreg_q[DW-1:1]};
            cnt_d    = '0;
            bitcnt_d = bitcnt_q + BW'(1);
            if (bitcnt_q == BW'(DW - 1)) begin
              state_d = STOP;
            end
          end else begin
            cnt_d = cnt_q + DIVW'(1);
          end
        end
        STOP: begin
          if (cnt_q == bit_last) begin
            if (rxs) begin
              frame_ok = 1'b1;
              state_d  = IDLE;
            end else begin
              frame_bad = 1'b1;
              state_d   = BREAK;
            end
          end else begin
            cnt_d = cnt_q + DIVW'(1);
          end
        end
        BREAK: begin
          if (rxs) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A good frame only lands in dout if the register is free or being read
  // in the same cycle; otherwise it is dropped and flagged as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DIVW'(MIN_BAUDDIV);
      bitcnt_q <= '0;
      shreg_q  <= '0;
      dout     <= '0;
      dvalid   <= 1'b0;
      ferr     <= 1'b0;
      oerr     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      ferr     <= frame_bad;
      oerr     <= 1'b0;
      if (frame_ok) begin
        if (!dvalid || dread) begin
          dout   <= shreg_q;
          dvalid <= 1'b1;
        end else begin
          oerr <= 1'b1;
        end
      end else if (dread) begin
        dvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DW, default 8: data bits per frame, sent LSB first.
REQ-002 Parameter DIVW, default 8: width of the baud divisor.
REQ-003 CLK  in  1: sole clock; all state changes on the rising edge.
REQ-004 NRST  in  1: reset, asynchronous and active-low.
REQ-005 EN  in  1: receiver enable; 0 forces IDLE and blocks start detection.
REQ-006 BAUDDIV  in  DIVW: clocks per bit (D); values below 2 are treated as 2.
REQ-007 RX  in  1: asynchronous serial input; idle level is 1.
REQ-008 DREAD  in  1: single-cycle pulse from the data register consuming DOUT.
REQ-009 DOUT  out  DW: last received byte.
REQ-010 DVALID  out  1: DOUT holds unread data.
REQ-011 FERR  out  1: one-cycle pulse on a framing error.
REQ-012 OERR  out  1: one-cycle pulse on an overrun.
REQ-013 BUSY  out  1: high in every state except IDLE.

Function
REQ-014 RX shall pass through a 2-flop synchronizer (reset value 1); all logic uses only the synchronized value rxs.
REQ-015 States: IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: when EN=1 and rxs=0, go to START and set cnt=0.
REQ-017 START: at cnt==floor(D/2)-1, sample rxs.
  - rxs=1 is a false start: go to IDLE, no flags.
  - rxs=0: set cnt=0 and go to DATA.
REQ-018 DATA: at cnt==D-1, shift rxs into the MSB of the shift register (shift right) and set cnt=0.
  - After DW samples, go to STOP.
REQ-019 STOP: at cnt==D-1, sample rxs.
  - 1: frame is good; go to IDLE.
  - 0: pulse FERR, discard the byte, go to BREAK.
REQ-020 BREAK: stay until rxs=1, then go to IDLE.
REQ-021 Otherwise cnt increments by 1 every cycle in START/DATA/STOP; cnt is DIVW bits and never wraps within a bit.
REQ-022 On a good frame, DOUT and DVALID=1 shall update on the clock edge that samples the stop bit (DOUT stable from the following cycle).
REQ-023 DREAD with DVALID=1 clears DVALID next cycle; DREAD with DVALID=0 is ignored.
REQ-024 Good frame while DVALID=1 and no DREAD: OERR pulses, DOUT and DVALID are unchanged, the new byte is dropped.
REQ-025 Good frame and DREAD in the same cycle: load the new byte, DVALID stays 1, no OERR.
REQ-026 EN deasserted mid-frame: return to IDLE next cycle and discard the partial byte; DOUT/DVALID are unaffected.
REQ-027 BAUDDIV is sampled on the IDLE->START transition and held for the whole frame.

Reset
REQ-028 NRST low shall immediately force:
  - state=IDLE, cnt=0, shift register=0;
  - DOUT=0, DVALID=0, FERR=0, OERR=0, BUSY=0;
  - synchronizer flops=1.
REQ-029 Reset mid-frame abandons the frame; after release, reception restarts only on a new falling edge.

Structure
REQ-030 Package uart_pkg shall hold the rx_state_t enum (IDLE, START, DATA, STOP, BREAK) and the constant MIN_BAUDDIV=2, shared with the transmitter and the register file.
REQ-031 The 2-flop synchronizer shall be a separate sub-module sync2 (asynchronous active-low reset, reset value parameterized); everything else stays in uart_rx.

Verification
REQ-032 D=16, frame 0x55 with a good stop bit -> DOUT=0x55, DVALID=1 exactly 2+7+1+16*9 cycles after RX falls; FERR=0, OERR=0.
REQ-033 D=16, RX low for only 4 cycles -> false start: BUSY returns to 0, DVALID stays 0, no flags.
REQ-034 D=8, frame 0xA3 with stop bit 0, RX held low 30 cycles -> one FERR pulse, DVALID=0, BUSY held until RX returns high.
REQ-035 D=8, two frames 0x11 then 0x22, no DREAD -> OERR pulses once, DOUT=0x11; repeat with DREAD coincident with the second stop sample -> DOUT=0x22, DVALID=1, no OERR.
REQ-036 D=16, NRST asserted mid-DATA -> all outputs return to reset values immediately; a following frame 0xC3 is received correctly.
REQ-037 BAUDDIV=0 and 1 behave identically to BAUDDIV=2 for frame 0x5A.
